// File: rtl/mul_ctrl.sv
// RV32M multiply controller: captures operand magnitudes and result sign, waits LAT cycles
// on a single unsigned 32x32 multiplier, then holds the signed-corrected result until taken.
module mul_ctrl #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  funct,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_res,
  output logic        busy
);

  localparam int unsigned CW = 3;
  localparam logic [1:0] F_MUL    = 2'b00;
  localparam logic [1:0] F_MULHU  = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     funct_q, funct_d;
  logic [31:0]    mag1_q, mag1_d;
  logic [31:0]    mag2_q, mag2_d;
  logic           sign_q, sign_d;
  logic [63:0]    prod_q, prod_d;
  logic [63:0]    mul_p;

  logic           op1_neg, op2_neg;
  logic [31:0]    op1_mag, op2_mag;

  Mul32U u_mul (
    .a (mag1_q),
    .b (mag2_q),
    .p (mul_p)
  );

  // op1 is signed unless MULHU; op2 is signed only for MUL/MULH (funct[1]==0).
  always_comb begin
    op1_neg = (funct != F_MULHU) && op1[31];
    op2_neg = !funct[1] && op2[31];
    op1_mag = op1_neg ? (~op1 + 32'd1) : op1;
    op2_mag = op2_neg ? (~op2 + 32'd1) : op2;
  end

  // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    funct_d = funct_q;
    mag1_d  = mag1_q;
    mag2_d  = mag2_q;
    sign_d  = sign_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          funct_d = funct;
          mag1_d  = op1_mag;
          mag2_d  = op2_mag;
          sign_d  = op1_neg ^ op2_neg;
          cnt_d   = CW'(LAT - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          // Two's-complement negation of zero is zero, so no -0 special case is needed.
          prod_d  = sign_q ? (~mul_p + 64'd1) : mul_p;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      funct_q <= '0;
      mag1_q  <= '0;
      mag2_q  <= '0;
      sign_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      funct_q <= funct_d;
      mag1_q  <= mag1_d;
      mag2_q  <= mag2_d;
      sign_q  <= sign_d;
      prod_q  <= prod_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_res   = (funct_q == F_MUL) ? prod_q[31:0] : prod_q[63:32];

endmodule

// Combinational 32x32 unsigned multiplier with full 64-bit product.
module Mul32U (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);
  assign p = {32'd0, a} * {32'd0, b};
endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl: directed vectors plus a queue-based reference model.
module tb_mul_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  funct;
  logic [31:0] op1, op2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_res;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  mul_ctrl #(.LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .funct     (funct),
    .op1       (op1),
    .op2       (op2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: extend each operand per its signedness and take the low 64 bits of the product.
  function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (f != 2'b11) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (f[1] == 1'b0) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  logic [31:0] exp_q[$];
  int          acc_q[$];
  bit          prev_v, prev_hs;
  logic [31:0] prev_res;
  bit          ev;

  // One outstanding operation at most: busy/req_ready follow the queue, rsp_valid follows latency.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_res", rsp_res, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 1);
      exp_q.delete();
      acc_q.delete();
      prev_v = 0;
    end else begin
      ev = (exp_q.size() > 0) && (cyc >= acc_q[0] + LAT);
      check("mon_rsp_valid", rsp_valid, ev);
      check("mon_busy", busy, exp_q.size() > 0);
      check("mon_req_ready", req_ready, exp_q.size() == 0);
      if (rsp_valid && exp_q.size() > 0) check("mon_rsp_res", rsp_res, exp_q[0]);
      if (prev_v && !prev_hs && rsp_valid) check("mon_hold", rsp_res, prev_res);
      prev_v   = rsp_valid;
      prev_hs  = rsp_ready;
      prev_res = rsp_res;
      if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
      end
      if (req_valid && req_ready) begin
        exp_q.push_back(model(funct, op1, op2));
        acc_q.push_back(cyc + 1);
      end
    end
  end

  task automatic wait_ready(input string name);
    bit got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1; break; end
    end
    check({name, "_accept"}, got, 1);
  endtask

  task automatic wait_rsp(input string name, output int lat);
    bit got = 0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; lat = i; break; end
    end
    check({name, "_rsp_seen"}, got, 1);
  endtask

  task automatic do_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name);
    int lat;
    funct = f; op1 = a; op2 = b; req_valid = 1'b1;
    wait_ready(name);
    @(posedge clk); #1;
    req_valid = 1'b0;
    op1 = $urandom; op2 = $urandom; funct = 2'($urandom);
    wait_rsp(name, lat);
    check({name, "_lat"}, lat, LAT);
    check(name, rsp_res, exp);
    @(posedge clk); #1;
  endtask

  int lat_b;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b1; funct = 2'b00; op1 = 32'd3; op2 = 32'd4; rsp_ready = 1'b1;
    #2;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_res", rsp_res, 0);
    check("reset_busy", busy, 0);
    check("reset_req_ready", req_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("no_capture_in_reset", busy, 0);

    do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ff");
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ff");
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, "mul_min");
    do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff");
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_ff");
    do_op(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
    do_op(2'b01, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, "mulh_m7_3");
    do_op(2'b11, 32'h8000_0000, 32'd2, 32'h0000_0001, "mulhu_carry");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "mulhsu_min");
    do_op(2'b01, 32'd0, 32'hFFFF_FFFB, 32'h0000_0000, "mulh_zero_neg");
    do_op(2'b00, 32'd0, 32'hFFFF_FFFB, 32'h0000_0000, "mul_zero_neg");

    // Backpressure: response held for 5 cycles while a second request waits.
    rsp_ready = 1'b0;
    funct = 2'b00; op1 = 32'd6; op2 = 32'd7; req_valid = 1'b1;
    wait_ready("bp_a");
    @(posedge clk); #1;
    op1 = 32'd3; op2 = 32'd5;
    wait_rsp("bp_a", lat_b);
    for (int i = 0; i < 5; i++) begin
      check("bp_res", rsp_res, 32'd42);
      check("bp_req_ready", req_ready, 0);
      check("bp_valid", rsp_valid, 1);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_at_release", rsp_valid, 1);
    @(posedge clk); #1;
    check("bp_idle_after_hs", req_ready, 1);
    check("bp_not_busy_after_hs", busy, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_b_accepted", busy, 1);
    wait_rsp("bp_b", lat_b);
    check("bp_b_res", rsp_res, 32'd15);
    @(posedge clk); #1;

    // Reset in the middle of a calculation discards the operation.
    funct = 2'b01; op1 = 32'h1234_5678; op2 = 32'h9ABC_DEF0; req_valid = 1'b1;
    wait_ready("rst_op");
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_res", rsp_res, 0);
    check("midrst_busy", busy, 0);
    check("midrst_req_ready", req_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    do_op(2'b00, 32'd1000, 32'd1000, 32'd1000000, "after_rst");

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
